// File: rtl/pc_pkg.sv
// Shared types and defaults for the program-counter / fetch-sequencing stage.
package pc_pkg;

    typedef enum logic [1:0] {IDLE, RUN, HALT} pc_state_t;

    localparam int PC_W     = 10;
    localparam int CNT_W    = 16;
    localparam int START_PC = 0;

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC selection: priority ordering and modulo-2^D arithmetic.
// Optional call/return link path enabled by the PC_LINK_EN macro.
module pc_next_calc #(
    parameter int D = 10
) (
    input  logic [D-1:0] pc,
    input  logic [D-1:0] target,
`ifdef PC_LINK_EN
    input  logic [D-1:0] link,
    input  logic         ret,
`endif
    input  logic         halt,
    input  logic         stall,
    input  logic         call,
    input  logic         jump_abs,
    input  logic         branch_rel,
    input  logic         taken,
    output logic [D-1:0] next_pc
);

    always_comb begin
        next_pc = pc + D'(1);
        if (halt || stall) begin
            next_pc = pc;
        end else if (call) begin
            // Without the link register a call is just an absolute jump.
            next_pc = target;
`ifdef PC_LINK_EN
        end else if (ret) begin
            next_pc = link;
`endif
        end else if (jump_abs) begin
            next_pc = target;
        end else if (branch_rel && taken) begin
            // Two's-complement add modulo 2^D equals unsigned add truncated to D bits.
            next_pc = pc + target;
        end
    end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// PC / fetch sequencer with IDLE/RUN/HALT control and a saturating retire counter.
// Optional one-entry call/return link register enabled by the PC_LINK_EN macro.
module pc_fetch_ctrl
    import pc_pkg::*;
#(
    parameter int D        = PC_W,
    parameter int CW       = CNT_W,
    parameter int START_PC = pc_pkg::START_PC
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          stall,
    input  logic          halt,
    input  logic          jump_abs,
    input  logic          branch_rel,
    input  logic          taken,
    input  logic          call,
    input  logic          ret,
    input  logic [D-1:0]  target,
    output logic [D-1:0]  pc,
    output logic          running,
    output logic          done,
    output logic [CW-1:0] instr_cnt
);

    localparam logic [D-1:0] PC_INIT = D'(START_PC);

    pc_state_t    state;
    logic [D-1:0] next_pc;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (&v) ? v : v + CW'(1);
    endfunction

`ifdef PC_LINK_EN
    logic [D-1:0] link;
`else
    logic unused_ret;
    assign unused_ret = ret;
`endif

    pc_next_calc #(.D(D)) u_next (
        .pc         (pc),
        .target     (target),
`ifdef PC_LINK_EN
        .link       (link),
        .ret        (ret),
`endif
        .halt       (halt),
        .stall      (stall),
        .call       (call),
        .jump_abs   (jump_abs),
        .branch_rel (branch_rel),
        .taken      (taken),
        .next_pc    (next_pc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            pc        <= PC_INIT;
            running   <= 1'b0;
            done      <= 1'b0;
            instr_cnt <= '0;
`ifdef PC_LINK_EN
            link      <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    pc <= PC_INIT;
                    if (start) begin
                        state     <= RUN;
                        running   <= 1'b1;
                        done      <= 1'b0;
                        instr_cnt <= '0;
`ifdef PC_LINK_EN
                        link      <= '0;
`endif
                    end
                end
                RUN: begin
                    pc <= next_pc;
                    // A halt retires even when a stall is asserted alongside it.
                    if (halt || !stall) begin
                        instr_cnt <= sat_inc(instr_cnt);
                    end
                    if (halt) begin
                        state   <= HALT;
                        running <= 1'b0;
                        done    <= 1'b1;
                    end
`ifdef PC_LINK_EN
                    if (!halt && !stall && call) begin
                        link <= pc + D'(1);
                    end
`endif
                end
                HALT: begin
                    if (start) begin
                        state     <= RUN;
                        running   <= 1'b1;
                        done      <= 1'b0;
                        pc        <= PC_INIT;
                        instr_cnt <= '0;
`ifdef PC_LINK_EN
                        link      <= '0;
`endif
                    end
                end
                default: begin
                    state   <= IDLE;
                    pc      <= PC_INIT;
                    running <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed self-checking bench for pc_fetch_ctrl; a second small-counter instance checks saturation.
module tb_pc_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, stall, halt, jump_abs, branch_rel, taken, call, ret;
    logic [9:0]  target;
    logic [9:0]  pc, pc2;
    logic        running, done, running2, done2;
    logic [15:0] instr_cnt;
    logic [3:0]  instr_cnt2;

    int total = 0;
    int bad   = 0;
    logic [9:0] exp_ret_pc;

    always #5 clk = ~clk;

    pc_fetch_ctrl #(.D(10), .CW(16), .START_PC(0)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stall(stall), .halt(halt),
        .jump_abs(jump_abs), .branch_rel(branch_rel), .taken(taken),
        .call(call), .ret(ret), .target(target),
        .pc(pc), .running(running), .done(done), .instr_cnt(instr_cnt)
    );

    pc_fetch_ctrl #(.D(10), .CW(4), .START_PC(0)) dut_sat (
        .clk(clk), .rst_n(rst_n), .start(start), .stall(stall), .halt(halt),
        .jump_abs(jump_abs), .branch_rel(branch_rel), .taken(taken),
        .call(call), .ret(ret), .target(target),
        .pc(pc2), .running(running2), .done(done2), .instr_cnt(instr_cnt2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ctrl();
        start = 0; stall = 0; halt = 0; jump_abs = 0;
        branch_rel = 0; taken = 0; call = 0; ret = 0; target = '0;
    endtask

    initial begin
        clear_ctrl();
        rst_n = 1'b0;
        #12;
        check("reset_pc", pc, 0);
        check("reset_running", running, 0);
        check("reset_done", done, 0);
        check("reset_cnt", instr_cnt, 0);
        rst_n = 1'b1;

        // IDLE ignores controls other than start
        jump_abs = 1; target = 10'd7;
        step();
        check("idle_pc", pc, 0);
        check("idle_running", running, 0);
        clear_ctrl();

        start = 1;
        step();
        start = 0;
        check("start_pc", pc, 0);
        check("start_running", running, 1);
        check("start_cnt", instr_cnt, 0);
        for (int i = 1; i <= 5; i++) begin
            step();
            check($sformatf("incr_pc_%0d", i), pc, i);
        end
        check("incr_cnt", instr_cnt, 5);
        check("incr_running", running, 1);

        // Relative branches (cnt 6..9)
        jump_abs = 1; target = 10'd4;
        step();
        check("jump_to_4", pc, 4);
        clear_ctrl();
        branch_rel = 1; taken = 1; target = 10'h3FF;
        step();
        check("branch_minus1", pc, 3);
        target = 10'd20;
        step();
        check("branch_plus20", pc, 23);
        taken = 0;
        step();
        check("branch_not_taken", pc, 24);
        check("branch_cnt", instr_cnt, 9);
        clear_ctrl();

        // Wrap and priority (cnt 10..13)
        jump_abs = 1; target = 10'd1022;
        step();
        clear_ctrl();
        step();
        check("pc_1023", pc, 1023);
        step();
        check("pc_wrap", pc, 0);
        jump_abs = 1; branch_rel = 1; taken = 1; target = 10'd121;
        step();
        check("abs_wins", pc, 121);
        check("abs_cnt", instr_cnt, 13);
        clear_ctrl();

        // Stall (cnt 14 held)
        jump_abs = 1; target = 10'd11;
        step();
        clear_ctrl();
        check("sat_not_yet", instr_cnt2, 14);
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("stall_pc_%0d", i), pc, 11);
            check($sformatf("stall_cnt_%0d", i), instr_cnt, 14);
        end
        clear_ctrl();

        // Call / return (cnt 15..17)
        jump_abs = 1; target = 10'd10;
        step();
        clear_ctrl();
        call = 1; target = 10'd55;
        step();
        check("call_pc", pc, 55);
        clear_ctrl();
        ret = 1;
        step();
`ifdef PC_LINK_EN
        exp_ret_pc = 10'd11;
`else
        exp_ret_pc = 10'd56;
`endif
        check("ret_pc", pc, exp_ret_pc);
        check("ret_cnt", instr_cnt, 17);
        check("sat_small_cnt", instr_cnt2, 15);
        clear_ctrl();

        // halt + stall: halt wins and retires (cnt 18)
        halt = 1; stall = 1;
        step();
        clear_ctrl();
        check("halt_done", done, 1);
        check("halt_running", running, 0);
        check("halt_pc", pc, exp_ret_pc);
        check("halt_cnt", instr_cnt, 18);
        jump_abs = 1; target = 10'd300;
        step();
        step();
        check("halt_frozen_pc", pc, exp_ret_pc);
        check("halt_frozen_cnt", instr_cnt, 18);
        check("halt_frozen_done", done, 1);
        clear_ctrl();

        start = 1;
        step();
        clear_ctrl();
        check("restart_pc", pc, 0);
        check("restart_cnt", instr_cnt, 0);
        check("restart_running", running, 1);
        check("restart_done", done, 0);
        check("restart_small_cnt", instr_cnt2, 0);

        // Asynchronous reset mid-cycle at pc=80
        jump_abs = 1; target = 10'd79;
        step();
        clear_ctrl();
        step();
        check("pre_reset_pc", pc, 80);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_pc", pc, 0);
        check("async_rst_cnt", instr_cnt, 0);
        check("async_rst_running", running, 0);
        check("async_rst_done", done, 0);
        rst_n = 1'b1;
        step();
        check("post_reset_idle_pc", pc, 0);
        check("post_reset_idle_running", running, 0);

        // Long run: small counter saturates, wide one keeps counting
        start = 1;
        step();
        clear_ctrl();
        for (int i = 0; i < 20; i++) step();
        check("run20_pc", pc, 20);
        check("run20_cnt", instr_cnt, 20);
        check("run20_small_sat", instr_cnt2, 15);

        // start ignored while running
        start = 1;
        step();
        clear_ctrl();
        check("start_in_run_pc", pc, 21);
        check("start_in_run_cnt", instr_cnt, 21);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
